// File: rtl/ram_access_ctrl_pkg.sv
// ram_ctrl_pkg: shared types for the 5x5-window RAM access controller.
package ram_ctrl_pkg;
  localparam int WIN = 5;
  typedef logic signed [15:0] data_t;
  typedef data_t [WIN-1:0][WIN-1:0] window_t;
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} ctrl_state_t;
  typedef enum logic {CL_RD, CL_WR} client_t;
endpackage

// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: read client, write client and RAM pin bundle.
interface ram_access_ctrl_if import ram_ctrl_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_offset;
  logic rd_gnt;
  logic rd_valid;
  logic [WIN*WIN*DATA_W-1:0] rd_window;
  logic wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic wr_gnt;
  logic wr_ack;
  logic ram_enable;
  logic ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [ADDR_W-1:0] ram_offset;
  logic [DATA_W-1:0] ram_input_data;
  logic [WIN*WIN*DATA_W-1:0] ram_output_data;
  logic ram_finish;
  modport slave (
    input rd_req, rd_addr, rd_offset, wr_req, wr_addr, wr_data, ram_output_data, ram_finish,
    output rd_gnt, rd_valid, rd_window, wr_gnt, wr_ack,
    output ram_enable, ram_write, ram_address, ram_offset, ram_input_data
  );
  modport master (
    output rd_req, rd_addr, rd_offset, wr_req, wr_addr, wr_data, ram_output_data, ram_finish,
    input rd_gnt, rd_valid, rd_window, wr_gnt, wr_ack,
    input ram_enable, ram_write, ram_address, ram_offset, ram_input_data
  );
endinterface

// File: rtl/ram_access_ctrl_arb.sv
// rr_arbiter2: two-way round-robin; prio names the client that wins a tie.
module rr_arbiter2 import ram_ctrl_pkg::*; (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_rd,
  input  logic    req_wr,
  input  logic    upd,
  output logic    any,
  output client_t win
);
  client_t prio;
  always_comb begin
    any = req_rd | req_wr;
    win = (req_rd && req_wr) ? prio : (req_wr ? CL_WR : CL_RD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= CL_RD;
    else if (upd) prio <= (win == CL_RD) ? CL_WR : CL_RD;
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: arbitrates read-window and write-word clients onto the single RAM port.
module ram_access_ctrl import ram_ctrl_pkg::*; #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_access_ctrl_if.slave  bus,
  output logic              busy,
  output logic              timeout_err
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  ctrl_state_t state, next;
  client_t cl, win;
  logic any, upd, fin, tmo;
  logic [CNT_W-1:0] cnt;
  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_rd (bus.rd_req),
    .req_wr (bus.wr_req),
    .upd    (upd),
    .any    (any),
    .win    (win)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    upd  = state == IDLE && any;
    fin  = state == ACCESS && bus.ram_enable && bus.ram_finish;
    tmo  = state == ACCESS && bus.ram_enable && !bus.ram_finish && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    next = upd ? ACCESS : (fin || tmo) ? RELEASE : (state == RELEASE && !bus.ram_finish) ? IDLE : state;
  end
  // Enable rises one edge after the grant so address/data are settled while it is high.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cl                 <= CL_RD;
      cnt                <= '0;
      busy               <= 1'b0;
      timeout_err        <= 1'b0;
      bus.rd_gnt         <= 1'b0;
      bus.wr_gnt         <= 1'b0;
      bus.rd_valid       <= 1'b0;
      bus.wr_ack         <= 1'b0;
      bus.rd_window      <= '0;
      bus.ram_enable     <= 1'b0;
      bus.ram_write      <= 1'b0;
      bus.ram_address    <= '0;
      bus.ram_offset     <= '0;
      bus.ram_input_data <= '0;
    end else begin
      busy         <= next != IDLE;
      bus.rd_gnt   <= upd && win == CL_RD;
      bus.wr_gnt   <= upd && win == CL_WR;
      bus.rd_valid <= (fin || tmo) && cl == CL_RD;
      bus.wr_ack   <= (fin || tmo) && cl == CL_WR;
      bus.ram_enable <= (state == ACCESS && !bus.ram_enable) ? 1'b1 : (fin || tmo) ? 1'b0 : bus.ram_enable;
      if (tmo) timeout_err <= 1'b1;
      if (upd) begin
        cl                 <= win;
        cnt                <= '0;
        bus.ram_write      <= win == CL_WR;
        bus.ram_address    <= (win == CL_WR) ? bus.wr_addr : bus.rd_addr;
        bus.ram_offset     <= (win == CL_WR) ? ADDR_W'(0) : bus.rd_offset;
        bus.ram_input_data <= (win == CL_WR) ? bus.wr_data : DATA_W'(0);
      end else if (state == ACCESS && bus.ram_enable && !fin && !tmo) cnt <= cnt + 1'b1;
      if (cl == CL_RD && fin) bus.rd_window <= bus.ram_output_data;
      else if (cl == CL_RD && tmo) bus.rd_window <= '0;
    end
endmodule
